// File: rtl/syn_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | syn_counter_pkg: state type and default constants for the sync counters.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package syn_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    localparam int unsigned c_DEFAULT_WIDTH = 3;
    localparam int unsigned c_DEFAULT_DIV   = 1;

endpackage
`default_nettype wire

// File: rtl/syn_tick_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | syn_tick_div: clock-enable prescaler, one tick per DIV enabled cycles.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module syn_tick_div
    import syn_counter_pkg::*;
#(
    parameter int unsigned DIV = c_DEFAULT_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    generate
        if (DIV <= 1) begin : g_div_bypass
            logic w_unused;
            assign w_unused = ^{clk, rst_n, clr_i};
            assign tick_o   = en_i;
        end else begin : g_div_count
            localparam int unsigned CW = $clog2(DIV);

            logic [CW-1:0] r_cnt_q;
            logic          w_wrap;

            assign w_wrap = (r_cnt_q == CW'(DIV - 1));
            assign tick_o = en_i && w_wrap;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt_q <= '0;
                end else if (clr_i) begin
                    r_cnt_q <= '0;
                end else if (en_i) begin
                    r_cnt_q <= w_wrap ? '0 : r_cnt_q + CW'(1);
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/syn_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | syn_down_counter: loadable down counter, auto-reload, prescaler, tc pulse. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module syn_down_counter
    import syn_counter_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEFAULT_WIDTH,
    parameter int unsigned DIV   = c_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    cnt_state_t       r_state_q;
    logic [WIDTH-1:0] r_cnt_q;
    logic [WIDTH-1:0] r_reload_q;
    logic             r_tc_q;

    logic w_tick;
    logic w_div_en;
    logic w_div_clr;

    // A load restarts the prescale phase, so the load cycle never counts as enabled.
    assign w_div_en  = en && (r_state_q == RUN) && !load;
    assign w_div_clr = load || (r_state_q != RUN);

    syn_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (w_div_clr),
        .en_i   (w_div_en),
        .tick_o (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= IDLE;
            r_cnt_q    <= '0;
            r_reload_q <= '0;
            r_tc_q     <= 1'b0;
        end else begin
            r_tc_q <= 1'b0;
            if (load) begin
                r_cnt_q    <= load_val;
                r_reload_q <= load_val;
                r_state_q  <= (load_val != '0) ? RUN : DONE;
            end else if ((r_state_q == RUN) && w_tick) begin
                if (r_cnt_q > WIDTH'(1)) begin
                    r_cnt_q <= r_cnt_q - WIDTH'(1);
                end else if (r_cnt_q == WIDTH'(1)) begin
                    r_cnt_q <= '0;
                    r_tc_q  <= 1'b1;
                    if (!auto_reload) begin
                        r_state_q <= DONE;
                    end
                end else if (auto_reload) begin
                    r_cnt_q <= r_reload_q;
                end else begin
                    // Periodic mode was switched off while parked at zero.
                    r_state_q <= DONE;
                end
            end
        end
    end

    assign q    = r_cnt_q;
    assign tc   = r_tc_q;
    assign busy = (r_state_q == RUN);
    assign done = (r_state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_syn_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_syn_down_counter: directed self-checking bench for syn_down_counter.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_syn_down_counter;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       load, auto_reload, en;
    logic [2:0] load_val;
    logic [2:0] q;
    logic       tc, busy, done;

    logic       load4, auto4, en4;
    logic [2:0] load_val4;
    logic [2:0] q4;
    logic       tc4, busy4, done4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    syn_down_counter #(.WIDTH(3), .DIV(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .en          (en),
        .q           (q),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    syn_down_counter #(.WIDTH(3), .DIV(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load4),
        .load_val    (load_val4),
        .auto_reload (auto4),
        .en          (en4),
        .q           (q4),
        .tc          (tc4),
        .busy        (busy4),
        .done        (done4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int eq, input int etc, input int ebusy, input int edone);
        chk({tag, ".q"},    32'(q),    32'(eq));
        chk({tag, ".tc"},   32'(tc),   32'(etc));
        chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
        chk({tag, ".done"}, 32'(done), 32'(edone));
    endtask

    initial begin
        int exp_q;
        int en_cnt;

        rst_n = 1'b0;
        load = 1'b0; load_val = '0; auto_reload = 1'b0; en = 1'b0;
        load4 = 1'b0; load_val4 = '0; auto4 = 1'b0; en4 = 1'b0;

        // Reset acts before any clock edge
        #2;
        chk_all("rst", 0, 0, 0, 0);
        chk("rst4.q", 32'(q4), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        en = 1'b1;
        step();
        step();
        chk_all("idle", 0, 0, 0, 0);

        // Auto-reload mirror sequence 7..0,7
        load = 1'b1; load_val = 3'd7; auto_reload = 1'b1;
        step();
        load = 1'b0;
        chk_all("ar_load", 7, 0, 1, 0);
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_q = (23 - i) % 8;
            chk("ar.q",  32'(q),  32'(exp_q));
            chk("ar.tc", 32'(tc), (exp_q == 0) ? 32'd1 : 32'd0);
        end

        // One-shot 3,2,1,0 then park in DONE
        load = 1'b1; load_val = 3'd3; auto_reload = 1'b0;
        step();
        load = 1'b0;
        chk_all("os_load", 3, 0, 1, 0);
        step();
        chk_all("os2", 2, 0, 1, 0);
        step();
        chk_all("os1", 1, 0, 1, 0);
        step();
        chk_all("os0", 0, 1, 0, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk_all("os_hold", 0, 0, 0, 1);
        end

        // Enable low holds count and state
        load = 1'b1; load_val = 3'd3;
        step();
        load = 1'b0;
        en = 1'b0;
        step();
        step();
        chk_all("en_hold", 3, 0, 1, 0);
        en = 1'b1;
        step();
        chk_all("en_resume", 2, 0, 1, 0);

        // Load on the tick that would take q from 1 to 0
        load = 1'b1; load_val = 3'd2; auto_reload = 1'b1;
        step();
        load = 1'b0;
        step();
        chk_all("col_pre", 1, 0, 1, 0);
        load = 1'b1; load_val = 3'd5;
        step();
        load = 1'b0;
        chk_all("col_load", 5, 0, 1, 0);
        step();
        chk_all("col_after", 4, 0, 1, 0);

        // Load of zero goes straight to DONE
        load = 1'b1; load_val = 3'd0;
        step();
        load = 1'b0;
        chk_all("ld0", 0, 0, 0, 1);
        step();
        chk_all("ld0_hold", 0, 0, 0, 1);

        // Asynchronous reset mid-count
        load = 1'b1; load_val = 3'd6; auto_reload = 1'b0;
        step();
        load = 1'b0;
        step();
        step();
        chk_all("ar_pre", 4, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("post_rst", 0, 0, 0, 0);
        end

        // Prescaler DIV=4 with enable toggled every other cycle
        load4 = 1'b1; load_val4 = 3'd2; auto4 = 1'b0; en4 = 1'b1;
        step();
        load4 = 1'b0;
        chk("div_load.q", 32'(q4), 32'd2);
        chk("div_load.busy", 32'(busy4), 32'd1);
        en_cnt = 0;
        for (int j = 0; j < 16; j++) begin
            en4 = (j % 2 == 1);
            step();
            if (en4) en_cnt++;
            exp_q = (en_cnt < 4) ? 2 : (en_cnt < 8) ? 1 : 0;
            chk("div.q",  32'(q4),  32'(exp_q));
            chk("div.tc", 32'(tc4), (en4 && en_cnt == 8) ? 32'd1 : 32'd0);
        end
        chk("div.done", 32'(done4), 32'd1);
        chk("div.busy", 32'(busy4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
